// File: rtl/rf_wb_scheduler_if.sv
// Bundles the issue, hazard-query, two writeback sources and RF write port of rf_wb_scheduler.
// The master side is decode/EX/LSU; the slave side is the scheduler.
interface rf_wb_scheduler_if #(
  parameter int XLEN = 32
);
  logic            issue_valid_i;
  logic [4:0]      issue_rd_i;
  logic            issue_ready_o;
  logic [4:0]      rs1_addr_i;
  logic [4:0]      rs2_addr_i;
  logic            hazard_o;
  logic            wb0_valid_i;
  logic [4:0]      wb0_rd_i;
  logic [XLEN-1:0] wb0_data_i;
  logic            wb0_ready_o;
  logic            wb1_valid_i;
  logic [4:0]      wb1_rd_i;
  logic [XLEN-1:0] wb1_data_i;
  logic            wb1_ready_o;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;

  modport master (
    output issue_valid_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
    output wb0_valid_i, wb0_rd_i, wb0_data_i,
    output wb1_valid_i, wb1_rd_i, wb1_data_i,
    input  issue_ready_o, hazard_o, wb0_ready_o, wb1_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o
  );

  modport slave (
    input  issue_valid_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
    input  wb0_valid_i, wb0_rd_i, wb0_data_i,
    input  wb1_valid_i, wb1_rd_i, wb1_data_i,
    output issue_ready_o, hazard_o, wb0_ready_o, wb1_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Round-robin arbiter of ALU/LSU writebacks onto the RF write port plus pending-write scoreboard.
// Grant in cycle N writes the RF in N+1; losers and WAW issues are held off via ready/issue_ready.
module rf_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rf_wb_scheduler_if.slave bus
);
  logic [NREG-1:0] busy_q, busy_d;
  logic            last_grant_q, last_grant_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            gnt0, gnt1, issue_acc;

  // last_grant_q = 1 means src1 won most recently, so src0 wins the next contention.
  assign gnt0 = bus.wb0_valid_i & (~bus.wb1_valid_i | last_grant_q);
  assign gnt1 = bus.wb1_valid_i & (~bus.wb0_valid_i | ~last_grant_q);

  assign issue_acc         = bus.issue_valid_i & ~busy_q[bus.issue_rd_i];
  assign bus.issue_ready_o = issue_acc;
  assign bus.hazard_o      = busy_q[bus.rs1_addr_i] | busy_q[bus.rs2_addr_i];
  assign bus.wb0_ready_o   = gnt0;
  assign bus.wb1_ready_o   = gnt1;
  assign bus.rf_we_o       = rf_we_q;
  assign bus.rf_waddr_o    = rf_waddr_q;
  assign bus.rf_wdata_o    = rf_wdata_q;

  always_comb begin
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    busy_d       = busy_q;

    if (gnt0) begin
      last_grant_d = 1'b0;
      rf_we_d      = (bus.wb0_rd_i != 5'd0);
      rf_waddr_d   = bus.wb0_rd_i;
      rf_wdata_d   = bus.wb0_data_i;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
      rf_we_d      = (bus.wb1_rd_i != 5'd0);
      rf_waddr_d   = bus.wb1_rd_i;
      rf_wdata_d   = bus.wb1_data_i;
    end

    // Clear on commit first so a same-cycle issue to the same register keeps it busy.
    if (rf_we_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (issue_acc) begin
      busy_d[bus.issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q       <= '0;
      last_grant_q <= 1'b1;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: reset, single path, contention, fairness, x0, scoreboard corner cases.
module tb_rf_wb_scheduler;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  rf_wb_scheduler_if #(.XLEN(32)) bus ();

  rf_wb_scheduler #(.XLEN(32), .NREG(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs are driven here, checks follow after #1.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i    = 5'd0;
    bus.rs1_addr_i    = 5'd0;
    bus.rs2_addr_i    = 5'd0;
    bus.wb0_valid_i   = 1'b0;
    bus.wb0_rd_i      = 5'd0;
    bus.wb0_data_i    = 32'd0;
    bus.wb1_valid_i   = 1'b0;
    bus.wb1_rd_i      = 5'd0;
    bus.wb1_data_i    = 32'd0;
  endtask

  initial begin
    idle();

    // Reset held two cycles; queries made while reset is still asserted so nothing is accepted.
    cyc();
    chk("rst_we", bus.rf_we_o, 1'b0);
    cyc();
    bus.rs1_addr_i = 5'd9; bus.rs2_addr_i = 5'd31;
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd5;
    #1;
    chk("rst_we2", bus.rf_we_o, 1'b0);
    chk("rst_waddr", bus.rf_waddr_o, 5'd0);
    chk("rst_wdata", bus.rf_wdata_o, 32'd0);
    chk("rst_hazard", bus.hazard_o, 1'b0);
    chk("rst_issue_rdy", bus.issue_ready_o, 1'b1);
    cyc();
    rst_i = 1'b0;
    idle();

    // Single path: issue rd3, then ALU writes it back.
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd3;
    #1 chk("sp_issue_rdy", bus.issue_ready_o, 1'b1);
    cyc();
    idle();
    bus.rs1_addr_i = 5'd3;
    bus.wb0_valid_i = 1'b1; bus.wb0_rd_i = 5'd3; bus.wb0_data_i = 32'hDEADBEEF;
    #1;
    chk("sp_haz_N", bus.hazard_o, 1'b1);
    chk("sp_wb0_rdy", bus.wb0_ready_o, 1'b1);
    chk("sp_wb1_rdy", bus.wb1_ready_o, 1'b0);
    chk("sp_we_N", bus.rf_we_o, 1'b0);
    cyc();
    bus.wb0_valid_i = 1'b0;
    #1;
    chk("sp_we_N1", bus.rf_we_o, 1'b1);
    chk("sp_waddr_N1", bus.rf_waddr_o, 5'd3);
    chk("sp_wdata_N1", bus.rf_wdata_o, 32'hDEADBEEF);
    chk("sp_haz_N1", bus.hazard_o, 1'b1);
    cyc();
    #1;
    chk("sp_we_N2", bus.rf_we_o, 1'b0);
    chk("sp_haz_N2", bus.hazard_o, 1'b0);

    // Reset so src0 wins the first contention.
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    idle();

    // Contention: both valid, src0 first then src1.
    bus.wb0_valid_i = 1'b1; bus.wb0_rd_i = 5'd4; bus.wb0_data_i = 32'h11;
    bus.wb1_valid_i = 1'b1; bus.wb1_rd_i = 5'd5; bus.wb1_data_i = 32'h22;
    #1;
    chk("ct_wb0_rdy_N", bus.wb0_ready_o, 1'b1);
    chk("ct_wb1_rdy_N", bus.wb1_ready_o, 1'b0);
    cyc();
    bus.wb0_valid_i = 1'b0;
    #1;
    chk("ct_wb0_rdy_N1", bus.wb0_ready_o, 1'b0);
    chk("ct_wb1_rdy_N1", bus.wb1_ready_o, 1'b1);
    chk("ct_we_N1", bus.rf_we_o, 1'b1);
    chk("ct_waddr_N1", bus.rf_waddr_o, 5'd4);
    chk("ct_wdata_N1", bus.rf_wdata_o, 32'h11);
    cyc();
    bus.wb1_valid_i = 1'b0;
    #1;
    chk("ct_we_N2", bus.rf_we_o, 1'b1);
    chk("ct_waddr_N2", bus.rf_waddr_o, 5'd5);
    chk("ct_wdata_N2", bus.rf_wdata_o, 32'h22);
    cyc();
    #1 chk("ct_we_N3", bus.rf_we_o, 1'b0);

    // Fairness: last grant was src1, so alternation starts at src0.
    bus.wb0_valid_i = 1'b1; bus.wb0_rd_i = 5'd10; bus.wb0_data_i = 32'hA0;
    bus.wb1_valid_i = 1'b1; bus.wb1_rd_i = 5'd11; bus.wb1_data_i = 32'hB0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("fr_wb0_rdy%0d", i), bus.wb0_ready_o, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("fr_wb1_rdy%0d", i), bus.wb1_ready_o, (i % 2 == 1) ? 1'b1 : 1'b0);
      if (i > 0) begin
        chk($sformatf("fr_waddr%0d", i), bus.rf_waddr_o, (i % 2 == 1) ? 5'd10 : 5'd11);
        chk($sformatf("fr_wdata%0d", i), bus.rf_wdata_o, (i % 2 == 1) ? 32'hA0 : 32'hB0);
      end
      cyc();
    end
    bus.wb0_valid_i = 1'b0; bus.wb1_valid_i = 1'b0;
    #1;
    chk("fr_we_last", bus.rf_we_o, 1'b1);
    chk("fr_waddr_last", bus.rf_waddr_o, 5'd11);
    cyc();
    idle();

    // x0: issue rd0 never marks busy; LSU write to x0 is consumed without an RF write.
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd0;
    #1;
    chk("x0_issue_rdy", bus.issue_ready_o, 1'b1);
    chk("x0_haz_rs0", bus.hazard_o, 1'b0);
    cyc();
    idle();
    bus.rs1_addr_i = 5'd0; bus.rs2_addr_i = 5'd3;
    bus.wb1_valid_i = 1'b1; bus.wb1_rd_i = 5'd0; bus.wb1_data_i = 32'hFFFFFFFF;
    #1;
    chk("x0_haz_after", bus.hazard_o, 1'b0);
    chk("x0_wb1_rdy", bus.wb1_ready_o, 1'b1);
    cyc();
    bus.wb1_valid_i = 1'b0;
    #1 chk("x0_we", bus.rf_we_o, 1'b0);
    cyc();
    idle();

    // WAW: reg 7 committing while a new issue to 7 arrives.
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd7;
    cyc();
    idle();
    bus.wb0_valid_i = 1'b1; bus.wb0_rd_i = 5'd7; bus.wb0_data_i = 32'h77;
    #1 chk("waw_wb0_rdy", bus.wb0_ready_o, 1'b1);
    cyc();
    bus.wb0_valid_i = 1'b0;
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd7; bus.rs1_addr_i = 5'd7;
    #1;
    chk("waw_we_N", bus.rf_we_o, 1'b1);
    chk("waw_issue_rdy_N", bus.issue_ready_o, 1'b0);
    chk("waw_haz_N", bus.hazard_o, 1'b1);
    cyc();
    #1;
    chk("waw_haz_N1", bus.hazard_o, 1'b0);
    chk("waw_issue_rdy_N1", bus.issue_ready_o, 1'b1);
    cyc();
    bus.issue_valid_i = 1'b0;
    #1 chk("waw_haz_N2", bus.hazard_o, 1'b1);

    // Set beats clear: write to non-busy reg 8 commits while issue to 8 is accepted.
    bus.rs1_addr_i = 5'd8;
    bus.wb1_valid_i = 1'b1; bus.wb1_rd_i = 5'd8; bus.wb1_data_i = 32'h88;
    cyc();
    bus.wb1_valid_i = 1'b0;
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd8;
    #1;
    chk("sw_we", bus.rf_we_o, 1'b1);
    chk("sw_issue_rdy", bus.issue_ready_o, 1'b1);
    cyc();
    bus.issue_valid_i = 1'b0;
    #1 chk("sw_haz", bus.hazard_o, 1'b1);

    // Reset the cycle after a grant drops the pending write and the scoreboard.
    bus.wb0_valid_i = 1'b1; bus.wb0_rd_i = 5'd9; bus.wb0_data_i = 32'h99;
    #1 chk("rg_wb0_rdy", bus.wb0_ready_o, 1'b1);
    cyc();
    bus.wb0_valid_i = 1'b0;
    rst_i = 1'b1;
    #1 chk("rg_we_G1", bus.rf_we_o, 1'b1);
    cyc();
    rst_i = 1'b0;
    bus.rs1_addr_i = 5'd7; bus.rs2_addr_i = 5'd8;
    #1;
    chk("rg_we_G2", bus.rf_we_o, 1'b0);
    chk("rg_haz", bus.hazard_o, 1'b0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Schedules the single write port of the 32x32 RISC-V register file between two writeback sources: src0 is the ALU/EX result, src1 is the LSU load return.
- Keeps a 32-entry pending-write scoreboard, so decode can stall on RAW and WAW hazards.
- Sits between the execute/memory stages and rf_riscv; drives its write_enable/addr/data inputs from registered outputs.

Parameters:
- XLEN, 32, data width of the writeback path and register file.
- NREG, 32, number of architectural registers (address width = 5; fixed for RV32I).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- issue_valid_i  in  1  decode issues an instruction that will write rd
- issue_rd_i  in  5  destination register of the issued instruction
- issue_ready_o  out  1  issue accepted this cycle (combinational)
- rs1_addr_i  in  5  decode source register 1
- rs2_addr_i  in  5  decode source register 2
- hazard_o  out  1  rs1 or rs2 has a pending write (combinational)
- wb0_valid_i  in  1  ALU result valid
- wb0_rd_i  in  5  ALU destination
- wb0_data_i  in  XLEN  ALU result
- wb0_ready_o  out  1  ALU result granted (combinational)
- wb1_valid_i  in  1  LSU load data valid
- wb1_rd_i  in  5  LSU destination
- wb1_data_i  in  XLEN  LSU data
- wb1_ready_o  out  1  LSU data granted (combinational)
- rf_we_o  out  1  to rf_riscv write_enable_i (registered)
- rf_waddr_o  out  5  to rf_riscv write_addr_i (registered)
- rf_wdata_o  out  XLEN  to rf_riscv write_data_i (registered)

Behaviour:
- Reset, synchronous on rst_i high at a clock edge:
  - busy[31:0] = 0; rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0.
  - last_grant = 1, so src0 wins the first contention.
  - Reset mid-operation drops any in-flight write: rf_we_o is 0 in the cycle after reset.
- Handshake: valid/ready per source.
  - A transfer occurs when valid && ready at a rising edge.
  - A source must hold valid, rd and data stable until ready.
- Arbitration: at most one grant per cycle.
  - Only one source valid: that source is granted.
  - Both valid: the source not equal to last_grant is granted (round-robin).
  - last_grant updates only on a grant.
  - The ready outputs depend only on the valid inputs and last_grant; there is no combinational path from the data inputs.
- Write output: grant in cycle N puts rf_we_o = 1 with the winner's rd/data in cycle N+1; the register file updates at the end of N+1. No grant in cycle N gives rf_we_o = 0 in cycle N+1.
- x0 handling:
  - A granted write with rd = 0 is consumed (ready = 1) but produces rf_we_o = 0.
  - Issue with rd = 0 never sets busy; busy[0] is permanently 0.
  - rs = 0 never raises hazard_o.
- Scoreboard:
  - issue_ready_o = issue_valid_i && !busy[issue_rd_i] (WAW stall).
  - On an accepted issue with rd != 0, busy[rd] is set at the edge.
  - busy[rf_waddr_o] is cleared at the edge ending any cycle where rf_we_o = 1, i.e. when the data commits to the register file.
  - Set and clear of the same register in the same cycle: set wins.
  - hazard_o = busy[rs1_addr_i] | busy[rs2_addr_i]. There is no bypass; hazard stays high through the commit cycle and drops the cycle after.
- A writeback to a register whose busy bit is 0 is still performed; the clear is a no-op. This is not an error.
- Total latency, issue to hazard release: issue edge, then arbitrary execute time, then grant cycle N, then commit at end of N+1; hazard_o is low from N+2.

Test Plan:
- Reset: hold rst_i for 2 cycles → rf_we_o = 0, hazard_o = 0 for any rs, and issue_ready_o = 1 for issue_rd_i = 5.
- Single path: issue rd = 3, then wb0 valid with rd = 3, data 0xDEADBEEF at cycle N → wb0_ready_o = 1 at N; rf_we_o = 1, rf_waddr_o = 3, rf_wdata_o = 0xDEADBEEF at N+1; hazard_o for rs1 = 3 is 1 through N+1 and 0 at N+2.
- Contention: wb0 (rd = 4, 0x11) and wb1 (rd = 5, 0x22) both valid from cycle N → grants src0 at N and src1 at N+1; RF sees writes to 4 then 5 at N+1 and N+2.
- Fairness: both sources continuously valid for 6 cycles → grants alternate 0,1,0,1,0,1; no source starves.
- x0: issue rd = 0 → busy unchanged, rs1 = 0 gives hazard_o = 0; wb1 rd = 0 data 0xFFFFFFFF → wb1_ready_o = 1 and rf_we_o stays 0.
- Simultaneous events:
  - Register 7 busy and committing at cycle N while an issue for rd = 7 arrives at N: issue_ready_o = 0 (WAW); a retry at N+1 is accepted and busy[7] = 1 at N+2.
  - Separately, assert rst_i the cycle after a grant: rf_we_o is 0 in the next cycle.
